// File: rtl/ip_recv_if.sv
// Receive-side byte stream into ip_recv and the parsed payload/header metadata out of it.
// The master side drives the frame bytes; the slave side is the parser.
interface ip_recv_if;
    logic        rx_enable;
    logic [7:0]  data_in;
    logic        active;
    logic [7:0]  data_out;
    logic        hdr_valid;
    logic        hdr_error;
    logic        is_icmp;
    logic        is_udp;
    logic        broadcast;
    logic [31:0] source_ip;
    logic [31:0] destination_ip;
    logic [15:0] length;

    modport master (
        output rx_enable, data_in,
        input  active, data_out, hdr_valid, hdr_error, is_icmp, is_udp, broadcast,
               source_ip, destination_ip, length
    );

    modport slave (
        input  rx_enable, data_in,
        output active, data_out, hdr_valid, hdr_error, is_icmp, is_udp, broadcast,
               source_ip, destination_ip, length
    );
endinterface

// File: rtl/ip_recv.sv
// IPv4 receive parser: validates the header that follows the ethertype and forwards
// only the IP payload of accepted ICMP/UDP datagrams, with registered header metadata.
module ip_recv #(
    parameter bit          ACCEPT_BROADCAST = 1'b1,
    parameter int unsigned MAX_IHL          = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   local_ip,
    ip_recv_if.slave      rx
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ETYPE   = 3'd1;
    localparam logic [2:0] ST_HEADER  = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;
    localparam logic [3:0] MAX_IHL_C  = 4'(MAX_IHL);

    // Two end-around-carry folds bring the 20-bit sum into 16 bits; a valid header sums to all ones.
    function automatic logic csum_ok(input logic [19:0] sum);
        logic [16:0] fold1;
        logic [15:0] fold2;
        fold1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
        fold2 = fold1[15:0] + {15'd0, fold1[16]};
        return (fold2 == 16'hFFFF);
    endfunction

    logic [2:0]  state_r;
    logic [5:0]  hcnt_r;
    logic [19:0] csum_r;
    logic [7:0]  hi_r;
    logic [3:0]  ihl_r;
    logic [15:0] tot_len_r;
    logic        frag_bad_r;
    logic [7:0]  proto_r;
    logic [31:0] src_sr_r;
    logic [31:0] dst_sr_r;
    logic [15:0] pcnt_r;
    logic        rx_prev_r;

    logic        active_r;
    logic [7:0]  data_out_r;
    logic        hdr_valid_r;
    logic        hdr_error_r;
    logic        is_icmp_r;
    logic        is_udp_r;
    logic        broadcast_r;
    logic [31:0] source_ip_r;
    logic [31:0] destination_ip_r;
    logic [15:0] length_r;

    logic [15:0] hdr_len_s;
    logic        hdr_last_s;
    logic [19:0] word_sum_s;
    logic [31:0] dst_now_s;
    logic        byte0_ok_s;
    logic        dst_ok_s;
    logic        proto_ok_s;
    logic        hdr_ok_s;

    assign hdr_len_s  = {10'd0, ihl_r, 2'b00};
    assign hdr_last_s = (hcnt_r != 6'd0) && (hcnt_r == ({ihl_r, 2'b00} - 6'd1));
    assign word_sum_s = csum_r + {4'd0, hi_r, rx.data_in};
    // With IHL=5 the last destination byte is also the last header byte, so splice it in live.
    assign dst_now_s  = (hcnt_r == 6'd19) ? {dst_sr_r[23:0], rx.data_in} : dst_sr_r;
    assign byte0_ok_s = (rx.data_in[7:4] == 4'd4) && (rx.data_in[3:0] >= 4'd5) &&
                        (rx.data_in[3:0] <= MAX_IHL_C);
    assign dst_ok_s   = (dst_now_s == local_ip) ||
                        ((ACCEPT_BROADCAST == 1'b1) && (dst_now_s == 32'hFFFF_FFFF));
    assign proto_ok_s = (proto_r == 8'd1) || (proto_r == 8'd17);
    assign hdr_ok_s   = csum_ok(word_sum_s) && !frag_bad_r && proto_ok_s && dst_ok_s &&
                        (tot_len_r >= hdr_len_s);

    // Frame state machine, header capture, checksum accumulation and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r          <= ST_IDLE;
            hcnt_r           <= 6'd0;
            csum_r           <= 20'd0;
            hi_r             <= 8'd0;
            ihl_r            <= 4'd0;
            tot_len_r        <= 16'd0;
            frag_bad_r       <= 1'b0;
            proto_r          <= 8'd0;
            src_sr_r         <= 32'd0;
            dst_sr_r         <= 32'd0;
            pcnt_r           <= 16'd0;
            rx_prev_r        <= 1'b1;
            active_r         <= 1'b0;
            data_out_r       <= 8'd0;
            hdr_valid_r      <= 1'b0;
            hdr_error_r      <= 1'b0;
            is_icmp_r        <= 1'b0;
            is_udp_r         <= 1'b0;
            broadcast_r      <= 1'b0;
            source_ip_r      <= 32'd0;
            destination_ip_r <= 32'd0;
            length_r         <= 16'd0;
        end else begin
            rx_prev_r   <= rx.rx_enable;
            active_r    <= 1'b0;
            hdr_valid_r <= 1'b0;
            hdr_error_r <= 1'b0;
            if (!rx.rx_enable) begin
                state_r <= ST_IDLE;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        // rx_prev_r high means we came out of reset mid-frame: skip the remainder.
                        if (rx_prev_r)                  state_r <= ST_DISCARD;
                        else if (rx.data_in == 8'h08)   state_r <= ST_ETYPE;
                        else                            state_r <= ST_DISCARD;
                    end
                    ST_ETYPE: begin
                        if (rx.data_in == 8'h00) begin
                            state_r    <= ST_HEADER;
                            hcnt_r     <= 6'd0;
                            csum_r     <= 20'd0;
                            frag_bad_r <= 1'b0;
                        end else begin
                            state_r <= ST_DISCARD;
                        end
                    end
                    ST_HEADER: begin
                        hcnt_r <= hcnt_r + 6'd1;
                        if (hcnt_r[0]) csum_r <= word_sum_s;
                        else           hi_r   <= rx.data_in;
                        case (hcnt_r)
                            6'd0:    ihl_r           <= rx.data_in[3:0];
                            6'd2:    tot_len_r[15:8] <= rx.data_in;
                            6'd3:    tot_len_r[7:0]  <= rx.data_in;
                            6'd6:    frag_bad_r      <= |rx.data_in[5:0];
                            6'd7:    frag_bad_r      <= frag_bad_r | (|rx.data_in);
                            6'd9:    proto_r         <= rx.data_in;
                            default: proto_r         <= proto_r;
                        endcase
                        if ((hcnt_r >= 6'd12) && (hcnt_r <= 6'd15))
                            src_sr_r <= {src_sr_r[23:0], rx.data_in};
                        if ((hcnt_r >= 6'd16) && (hcnt_r <= 6'd19))
                            dst_sr_r <= {dst_sr_r[23:0], rx.data_in};
                        if (hcnt_r == 6'd0) begin
                            if (!byte0_ok_s) begin
                                hdr_error_r <= 1'b1;
                                state_r     <= ST_DISCARD;
                            end
                        end else if (hdr_last_s) begin
                            if (hdr_ok_s) begin
                                state_r          <= ST_PAYLOAD;
                                pcnt_r           <= tot_len_r - hdr_len_s;
                                hdr_valid_r      <= 1'b1;
                                length_r         <= tot_len_r - hdr_len_s;
                                source_ip_r      <= src_sr_r;
                                destination_ip_r <= dst_now_s;
                                is_icmp_r        <= (proto_r == 8'd1);
                                is_udp_r         <= (proto_r == 8'd17);
                                broadcast_r      <= (dst_now_s == 32'hFFFF_FFFF);
                            end else begin
                                hdr_error_r <= 1'b1;
                                state_r     <= ST_DISCARD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (pcnt_r == 16'd0) begin
                            state_r <= ST_DISCARD;
                        end else begin
                            data_out_r <= rx.data_in;
                            active_r   <= 1'b1;
                            pcnt_r     <= pcnt_r - 16'd1;
                            if (pcnt_r == 16'd1) state_r <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: state_r <= ST_DISCARD;
                    default:    state_r <= ST_IDLE;
                endcase
            end
        end
    end

    assign rx.active         = active_r;
    assign rx.data_out       = data_out_r;
    assign rx.hdr_valid      = hdr_valid_r;
    assign rx.hdr_error      = hdr_error_r;
    assign rx.is_icmp        = is_icmp_r;
    assign rx.is_udp         = is_udp_r;
    assign rx.broadcast      = broadcast_r;
    assign rx.source_ip      = source_ip_r;
    assign rx.destination_ip = destination_ip_r;
    assign rx.length         = length_r;

endmodule

// File: tb/tb_ip_recv.sv
// Scoreboard bench for ip_recv: a frame-level reference model queues expected events,
// a negedge monitor pops and compares them for a broadcast-accepting and a unicast-only instance.
module tb_ip_recv;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8010A;
    localparam int K_VALID = 0;
    localparam int K_ERR   = 1;
    localparam int K_BYTE  = 2;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int          kind;
        logic [7:0]  data;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
        logic        icmp;
        logic        udp;
        logic        bc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] local_ip;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          act_cnt0 = 0;
    int          act_cnt1 = 0;
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    exp_t        meta0;
    exp_t        meta1;

    always #5 clock = ~clock;

    ip_recv_if if_b ();
    ip_recv_if if_n ();
    assign if_n.rx_enable = if_b.rx_enable;
    assign if_n.data_in   = if_b.data_in;

    ip_recv #(.ACCEPT_BROADCAST(1'b1), .MAX_IHL(15)) dut_b (
        .clock(clock), .reset(reset), .local_ip(local_ip), .rx(if_b.slave));
    ip_recv #(.ACCEPT_BROADCAST(1'b0), .MAX_IHL(15)) dut_n (
        .clock(clock), .reset(reset), .local_ip(local_ip), .rx(if_n.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push(input int w, input exp_t e);
        if (w == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic take(input int w, output bit got, output exp_t e);
        e = '{default: 0};
        got = 1'b0;
        if (w == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); got = 1'b1; end
        if (w == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); got = 1'b1; end
    endtask

    // Reference model: interprets the first n delivered bytes of a frame as a whole.
    task automatic model(input byte_q_t fr, input int n, input int w);
        exp_t e;
        exp_t b;
        logic [7:0]  b0;
        logic [15:0] frag;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        int ihl, hl, tl, s, np;
        bit ok;
        e = '{default: 0};
        if (n < 3) return;
        if (fr[0] != 8'h08 || fr[1] != 8'h00) return;
        b0  = fr[2];
        ihl = int'(b0[3:0]);
        if (b0[7:4] != 4'd4 || ihl < 5) begin
            e.kind = K_ERR;
            push(w, e);
            return;
        end
        hl = ihl * 4;
        if (n < 2 + hl) return;
        tl    = int'({fr[4], fr[5]});
        frag  = {fr[8], fr[9]};
        proto = fr[11];
        src   = {fr[14], fr[15], fr[16], fr[17]};
        dst   = {fr[18], fr[19], fr[20], fr[21]};
        s = 0;
        for (int i = 0; i < hl; i += 2) s += int'({fr[2 + i], fr[3 + i]});
        while (s > 65535) s = (s & 65535) + (s >>> 16);
        ok = (s == 65535) && (frag[13:0] == 14'd0) && (proto == 8'd1 || proto == 8'd17) &&
             (dst == LOCAL_IP || (w == 0 && dst == 32'hFFFF_FFFF)) && (tl >= hl);
        if (!ok) begin
            e.kind = K_ERR;
            push(w, e);
            return;
        end
        e.kind = K_VALID;
        e.src  = src;
        e.dst  = dst;
        e.len  = 16'(tl - hl);
        e.icmp = (proto == 8'd1);
        e.udp  = (proto == 8'd17);
        e.bc   = (dst == 32'hFFFF_FFFF);
        push(w, e);
        if (w == 0) meta0 = e;
        else        meta1 = e;
        np = tl - hl;
        if (n - 2 - hl < np) np = n - 2 - hl;
        for (int i = 0; i < np; i++) begin
            b = '{default: 0};
            b.kind = K_BYTE;
            b.data = fr[2 + hl + i];
            push(w, b);
        end
    endtask

    task automatic build(output byte_q_t fr, input logic [15:0] etype, input logic [3:0] ver,
                         input logic [3:0] ihl, input logic [7:0] proto, input logic [31:0] src,
                         input logic [31:0] dst, input logic [15:0] frag, input int plen,
                         input int pad, input int tl_force, input bit bad_ck);
        byte_q_t h;
        int hl, tl, s;
        logic [15:0] ck;
        hl = (ihl < 4'd5) ? 20 : int'(ihl) * 4;
        tl = (tl_force >= 0) ? tl_force : hl + plen;
        h = {};
        h.push_back({ver, ihl});
        h.push_back(8'($urandom));
        h.push_back(8'(tl >> 8));
        h.push_back(8'(tl));
        h.push_back(8'($urandom));
        h.push_back(8'($urandom));
        h.push_back(frag[15:8]);
        h.push_back(frag[7:0]);
        h.push_back(8'd64);
        h.push_back(proto);
        h.push_back(8'h00);
        h.push_back(8'h00);
        for (int k = 3; k >= 0; k--) h.push_back(8'(src >> (8 * k)));
        for (int k = 3; k >= 0; k--) h.push_back(8'(dst >> (8 * k)));
        for (int i = 20; i < hl; i++) h.push_back(8'($urandom));
        s = 0;
        for (int i = 0; i < hl; i += 2) s += int'({h[i], h[i + 1]});
        while (s > 65535) s = (s & 65535) + (s >>> 16);
        ck = ~16'(s);
        if (bad_ck) ck = ck ^ 16'h0001;
        h[10] = ck[15:8];
        h[11] = ck[7:0];
        fr = {};
        fr.push_back(etype[15:8]);
        fr.push_back(etype[7:0]);
        foreach (h[i]) fr.push_back(h[i]);
        for (int i = 0; i < plen + pad; i++) fr.push_back(8'($urandom));
    endtask

    task automatic mon(input int w, input logic hv, input logic he, input logic act,
                       input logic [7:0] d, input logic [31:0] src, input logic [31:0] dst,
                       input logic [15:0] len, input logic icmp, input logic udp, input logic bc);
        exp_t e;
        bit got;
        if (hv === 1'b1) begin
            take(w, got, e);
            check($sformatf("inst%0d hdr_valid event", w), 32'(got && e.kind == K_VALID), 32'd1);
            if (got && e.kind == K_VALID) begin
                check($sformatf("inst%0d source_ip", w), src, e.src);
                check($sformatf("inst%0d destination_ip", w), dst, e.dst);
                check($sformatf("inst%0d length", w), 32'(len), 32'(e.len));
                check($sformatf("inst%0d proto flags", w), 32'({icmp, udp, bc}), 32'({e.icmp, e.udp, e.bc}));
            end
        end
        if (he === 1'b1) begin
            take(w, got, e);
            check($sformatf("inst%0d hdr_error event", w), 32'(got && e.kind == K_ERR), 32'd1);
        end
        if (act === 1'b1) begin
            if (w == 0) act_cnt0++;
            else        act_cnt1++;
            take(w, got, e);
            check($sformatf("inst%0d payload event", w), 32'(got && e.kind == K_BYTE), 32'd1);
            if (got && e.kind == K_BYTE) check($sformatf("inst%0d data_out", w), 32'(d), 32'(e.data));
        end
    endtask

    // Monitor: compares everything the two DUTs present against the scoreboard queues.
    always @(negedge clock) begin
        if (mon_en) begin
            mon(0, if_b.hdr_valid, if_b.hdr_error, if_b.active, if_b.data_out, if_b.source_ip,
                if_b.destination_ip, if_b.length, if_b.is_icmp, if_b.is_udp, if_b.broadcast);
            mon(1, if_n.hdr_valid, if_n.hdr_error, if_n.active, if_n.data_out, if_n.source_ip,
                if_n.destination_ip, if_n.length, if_n.is_icmp, if_n.is_udp, if_n.broadcast);
        end
    end

    task automatic send(input byte_q_t fr, input int n, input int rst_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (rst_at >= 0 && i == rst_at + 1) begin
                check("inst0 active after reset", 32'(if_b.active), 32'd0);
                check("inst1 active after reset", 32'(if_n.active), 32'd0);
            end
            if_b.rx_enable = 1'b1;
            if_b.data_in   = fr[i];
            reset          = (i == rst_at) ? 1'b0 : 1'b1;
        end
        @(posedge clock);
        #1;
        if_b.rx_enable = 1'b0;
        if_b.data_in   = 8'h00;
        reset          = 1'b1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clock);
        #1;
        check("inst0 pending events", 32'(exp_q0.size()), 32'd0);
        check("inst1 pending events", 32'(exp_q1.size()), 32'd0);
        check("inst0 held source_ip", if_b.source_ip, meta0.src);
        check("inst0 held length", 32'(if_b.length), 32'(meta0.len));
        check("inst0 held flags", 32'({if_b.is_icmp, if_b.is_udp, if_b.broadcast}), 32'({meta0.icmp, meta0.udp, meta0.bc}));
        check("inst1 held destination_ip", if_n.destination_ip, meta1.dst);
        check("inst1 held flags", 32'({if_n.is_icmp, if_n.is_udp, if_n.broadcast}), 32'({meta1.icmp, meta1.udp, meta1.bc}));
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic run(input byte_q_t fr, input int n, input int rst_at, input bit do_settle);
        int nm;
        nm = (rst_at >= 0) ? rst_at : n;
        model(fr, nm, 0);
        model(fr, nm, 1);
        if (rst_at >= 0) begin
            meta0 = '{default: 0};
            meta1 = '{default: 0};
        end
        send(fr, n, rst_at);
        if (do_settle) settle();
    endtask

    initial begin
        byte_q_t fr;
        byte_q_t fr2;
        logic [31:0] dst;
        logic [7:0]  proto;
        logic [15:0] frag;
        logic [3:0]  ver;
        logic [3:0]  ihl;
        int plen, tlf, n;
        meta0 = '{default: 0};
        meta1 = '{default: 0};
        reset = 1'b0;
        local_ip = LOCAL_IP;
        if_b.rx_enable = 1'b0;
        if_b.data_in = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        check("reset active/flags inst0", 32'({if_b.active, if_b.hdr_valid, if_b.hdr_error, if_b.is_icmp, if_b.is_udp, if_b.broadcast}), 32'd0);
        check("reset data_out inst0", 32'(if_b.data_out), 32'd0);
        check("reset source_ip inst0", if_b.source_ip, 32'd0);
        check("reset destination_ip inst0", if_b.destination_ip, 32'd0);
        check("reset length inst0", 32'(if_b.length), 32'd0);
        check("reset active/flags inst1", 32'({if_n.active, if_n.hdr_valid, if_n.hdr_error, if_n.is_icmp, if_n.is_udp, if_n.broadcast}), 32'd0);
        reset = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clock);

        // UDP to this node, 16 payload bytes and 10 padding bytes.
        act_cnt0 = 0; act_cnt1 = 0;
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'hC0A80101, LOCAL_IP, 16'h0000, 16, 10, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        check("udp active cycles inst0", 32'(act_cnt0), 32'd16);
        check("udp active cycles inst1", 32'(act_cnt1), 32'd16);
        check("udp length", 32'(if_b.length), 32'd16);
        // Same frame with a corrupted checksum.
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'hC0A80101, LOCAL_IP, 16'h0000, 16, 10, -1, 1'b1);
        run(fr, fr.size(), -1, 1'b1);
        check("bad checksum active cycles", 32'(act_cnt0), 32'd16);
        // ICMP broadcast: accepted only by the broadcast-enabled instance.
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd1, 32'h0A000001, 32'hFFFFFFFF, 16'h0000, 8, 0, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        check("bcast is_icmp/broadcast inst0", 32'({if_b.is_icmp, if_b.broadcast}), 32'd3);
        // IHL=6 with options; then MF set; then DF only.
        build(fr, 16'h0800, 4'd4, 4'd6, 8'd17, 32'h01020304, LOCAL_IP, 16'h0000, 12, 4, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        check("ihl6 length", 32'(if_b.length), 32'd12);
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'h01020304, LOCAL_IP, 16'h2000, 6, 0, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd1, 32'h05060708, LOCAL_IP, 16'h4000, 5, 2, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        // ARP, zero-length payload, short total_length, bad version, IHL=4.
        build(fr, 16'h0806, 4'd4, 4'd5, 8'd17, 32'h01020304, LOCAL_IP, 16'h0000, 8, 0, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        act_cnt0 = 0;
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'h0B0B0B0B, LOCAL_IP, 16'h0000, 0, 6, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        check("zero length active cycles", 32'(act_cnt0), 32'd0);
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'h01020304, LOCAL_IP, 16'h0000, 4, 0, 16, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        build(fr, 16'h0800, 4'd6, 4'd5, 8'd17, 32'h01020304, LOCAL_IP, 16'h0000, 4, 0, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        build(fr, 16'h0800, 4'd4, 4'd4, 8'd17, 32'h01020304, LOCAL_IP, 16'h0000, 4, 0, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        // Truncations: mid-header, then after 5 of 16 payload bytes.
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'h01020304, LOCAL_IP, 16'h0000, 16, 0, -1, 1'b0);
        run(fr, 12, -1, 1'b1);
        act_cnt0 = 0;
        run(fr, 27, -1, 1'b1);
        check("truncated active cycles", 32'(act_cnt0), 32'd5);
        // Reset mid-payload after 8 bytes, then a clean frame.
        act_cnt0 = 0;
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'h01020304, LOCAL_IP, 16'h0000, 16, 0, -1, 1'b0);
        run(fr, fr.size(), 30, 1'b1);
        check("reset frame active cycles", 32'(act_cnt0), 32'd8);
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd1, 32'h0C0C0C0C, LOCAL_IP, 16'h0000, 7, 3, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b1);
        // Back-to-back frames separated by one idle cycle.
        build(fr, 16'h0800, 4'd4, 4'd5, 8'd17, 32'hAABBCCDD, LOCAL_IP, 16'h0000, 3, 0, -1, 1'b0);
        build(fr2, 16'h0800, 4'd4, 4'd5, 8'd1, 32'h11223344, 32'hFFFFFFFF, 16'h0000, 4, 0, -1, 1'b0);
        run(fr, fr.size(), -1, 1'b0);
        run(fr2, fr2.size(), -1, 1'b1);

        // Randomized frames.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0:       proto = 8'd1;
                1:       proto = 8'd17;
                default: proto = ($urandom_range(0, 3) == 0) ? 8'd6 : 8'd17;
            endcase
            case ($urandom_range(0, 3))
                0:       dst = 32'hFFFFFFFF;
                1:       dst = $urandom;
                default: dst = LOCAL_IP;
            endcase
            case ($urandom_range(0, 7))
                0:       frag = 16'h2000;
                1:       frag = 16'h4000;
                2:       frag = 16'(1 + $urandom_range(0, 8190));
                default: frag = 16'h0000;
            endcase
            ver  = ($urandom_range(0, 9) == 0) ? 4'(6) : 4'd4;
            ihl  = 4'($urandom_range(4, 7));
            if ($urandom_range(0, 1) == 0) ihl = 4'd5;
            plen = $urandom_range(0, 20);
            tlf  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 19) : -1;
            build(fr, ($urandom_range(0, 9) == 0) ? 16'h86DD : 16'h0800, ver, ihl, proto,
                  $urandom, dst, frag, plen, $urandom_range(0, 6), tlf, ($urandom_range(0, 7) == 0));
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(1, fr.size()) : fr.size();
            run(fr, n, -1, ($urandom_range(0, 3) != 0) || (t == 59));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
